// File: rtl/image_readback.sv
// rtl/image_readback.sv - Avalon-MM read path draining one buffered image vector as WORD_W-bit words.
// Optional PEEK register at address 4 enabled by IMG_READBACK_PEEK_EN.
module image_readback #(
  parameter int IMG_BITS = 400,
  parameter int WORD_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_load_valid,
  output logic                o_load_ready,
  input  logic [IMG_BITS-1:0] i_load_image,
  input  logic                i_chipselect,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [2:0]          i_address,
  input  logic [WORD_W-1:0]   i_writedata,
  output logic [WORD_W-1:0]   o_readdata,
  output logic                o_done
);

  localparam int NWORDS = (IMG_BITS + WORD_W - 1) / WORD_W;
  localparam int PAD_W  = NWORDS * WORD_W;
  localparam int PTR_W  = $clog2(NWORDS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    w_ptr_nx;
  logic                r_done;
  logic                w_done_nx;
  logic [IMG_BITS-1:0] r_buf;
  logic [WORD_W-1:0]   r_readdata;
  logic [WORD_W-1:0]   w_rdata_nx;
  logic [PAD_W-1:0]    w_buf_pad;
  logic [WORD_W-1:0]   w_words [NWORDS];
  logic [PTR_W-1:0]    w_ptr_sel;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   w_status;
  logic                w_rd;
  logic                w_wr;
  logic                w_load_acc;
  logic                w_ctrl_wr;
  logic                w_data_rd;
  logic                w_unused_wdata;

  // A simultaneous read wins over write; CTRL only matters once something is buffered.
  assign w_rd          = i_chipselect && i_read;
  assign w_wr          = i_chipselect && i_write && !i_read;
  assign w_load_acc    = i_load_valid && (r_state == ST_EMPTY);
  assign w_ctrl_wr     = w_wr && (i_address == 3'd1) && (r_state != ST_EMPTY);
  assign w_data_rd     = w_rd && (i_address == 3'd3) && (r_state == ST_FULL);
  assign o_load_ready  = (r_state == ST_EMPTY);
  assign o_readdata    = r_readdata;
  assign o_done        = r_done;
  assign w_unused_wdata = ^i_writedata[WORD_W-1:2];

  // Zero-extend so a partial last word reads its unused upper bits as 0.
  assign w_buf_pad = PAD_W'(r_buf);
  assign w_ptr_sel = (r_ptr <= LAST_PTR) ? r_ptr : '0;
  assign w_word    = w_words[w_ptr_sel];
  assign w_status  = WORD_W'({r_state, r_done, r_ptr});

  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      w_words[i] = w_buf_pad[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    w_rdata_nx = '0;
    case (i_address)
      3'd0:    w_rdata_nx = w_status;
      3'd3:    w_rdata_nx = (r_state == ST_FULL) ? w_word : '0;
`ifdef IMG_READBACK_PEEK_EN
      3'd4:    w_rdata_nx = (r_state == ST_FULL) ? w_word : '0;
`else
      3'd4:    w_rdata_nx = '0;
`endif
      default: w_rdata_nx = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_done_nx  = r_done;
    case (r_state)
      ST_EMPTY: begin
        if (w_load_acc) begin
          w_state_nx = ST_FULL;
          w_ptr_nx   = '0;
          w_done_nx  = 1'b0;
        end
      end
      default: begin
        if (w_ctrl_wr && i_writedata[1]) begin
          w_state_nx = ST_EMPTY;
          w_ptr_nx   = '0;
          w_done_nx  = 1'b0;
        end else if (w_ctrl_wr && i_writedata[0]) begin
          w_state_nx = ST_FULL;
          w_ptr_nx   = '0;
          w_done_nx  = 1'b0;
        end else if (w_data_rd) begin
          w_ptr_nx = r_ptr + 1'b1;
          if (r_ptr == LAST_PTR) begin
            w_state_nx = ST_DRAINED;
            w_done_nx  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= '0;
      r_done     <= 1'b0;
      r_buf      <= '0;
      r_readdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_done  <= w_done_nx;
      if (w_load_acc) begin
        r_buf <= i_load_image;
      end
      if (w_rd) begin
        r_readdata <= w_rdata_nx;
      end
    end
  end

endmodule

// File: tb/tb_image_readback.sv
// tb/tb_image_readback.sv - self-checking bench for image_readback with a behavioural drain model.
module tb_image_readback;
  localparam int IMG_BITS = 400;
  localparam int WORD_W   = 16;
  localparam int NWORDS   = 25;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                load_valid;
  logic                load_ready;
  logic [IMG_BITS-1:0] load_image;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [2:0]          address;
  logic [WORD_W-1:0]   writedata;
  logic [WORD_W-1:0]   readdata;
  logic                done;

  int checks = 0;
  int errors = 0;

  logic [IMG_BITS-1:0] m_img;
  logic [1:0]          m_state;
  logic                m_done;
  int                  m_ptr;
  logic [WORD_W-1:0]   m_rdata;

  always #5 clk = ~clk;

  image_readback #(.IMG_BITS(IMG_BITS), .WORD_W(WORD_W)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_load_image (load_image),
    .i_chipselect (chipselect),
    .i_read       (read),
    .i_write      (write),
    .i_address    (address),
    .i_writedata  (writedata),
    .o_readdata   (readdata),
    .o_done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] m_word(input int idx);
    logic [IMG_BITS-1:0] t;
    t = m_img >> (idx * WORD_W);
    return t[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] model_read(input logic [2:0] a);
    logic [4:0] p;
    p = 5'(m_ptr);
    case (a)
      3'd0: return {8'h00, m_state, m_done, p};
      3'd3: return (m_state == 2'd1) ? m_word(m_ptr) : '0;
`ifdef IMG_READBACK_PEEK_EN
      3'd4: return (m_state == 2'd1) ? m_word(m_ptr) : '0;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic [IMG_BITS-1:0] rand_img();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
    return t[IMG_BITS-1:0];
  endfunction

  task automatic model_reset();
    m_img = '0; m_state = 2'd0; m_done = 1'b0; m_ptr = 0; m_rdata = '0;
  endtask

  task automatic step(input string tag, input logic lv, input logic [IMG_BITS-1:0] img,
                      input logic cs, input logic rd, input logic wr,
                      input logic [2:0] a, input logic [WORD_W-1:0] wd);
    @(negedge clk);
    load_valid = lv; load_image = img; chipselect = cs; read = rd; write = wr;
    address = a; writedata = wd;
    if (cs && rd) m_rdata = model_read(a);
    if (lv && m_state == 2'd0) begin
      m_img = img; m_state = 2'd1; m_ptr = 0; m_done = 1'b0;
    end else if (cs && rd) begin
      if (a == 3'd3 && m_state == 2'd1) begin
        m_ptr++;
        if (m_ptr == NWORDS) begin m_state = 2'd2; m_done = 1'b1; end
      end
    end else if (cs && wr && a == 3'd1 && m_state != 2'd0) begin
      if (wd[1]) begin m_state = 2'd0; m_ptr = 0; m_done = 1'b0; end
      else if (wd[0]) begin m_state = 2'd1; m_ptr = 0; m_done = 1'b0; end
    end
    @(posedge clk);
    #1;
    chk({tag, ".rdata"}, 32'(readdata), 32'(m_rdata));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".ready"}, 32'(load_ready), 32'(m_state == 2'd0));
    load_valid = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 3'd0; writedata = '0;
  endtask

  task automatic bus_rd(input string tag, input logic [2:0] a);
    step(tag, 1'b0, '0, 1'b1, 1'b1, 1'b0, a, '0);
  endtask

  task automatic bus_wr(input string tag, input logic [2:0] a, input logic [WORD_W-1:0] d);
    step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_load(input string tag, input logic [IMG_BITS-1:0] img);
    step(tag, 1'b1, img, 1'b0, 1'b0, 1'b0, 3'd0, '0);
  endtask

  initial begin
    logic [IMG_BITS-1:0] img_a;
    logic [IMG_BITS-1:0] img_b;
    reset_n = 1'b0; load_valid = 1'b0; load_image = '0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; address = 3'd0; writedata = '0;
    model_reset();
    #2;
    chk("reset.rdata", 32'(readdata), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    chk("reset.ready", 32'(load_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    bus_rd("empty_status", 3'd0);
    chk("empty_status_const", 32'(readdata), 32'h0);
    bus_rd("empty_data", 3'd3);
    bus_rd("empty_status2", 3'd0);

    img_a = rand_img();
    img_a[31:0] = 32'h0001_ABCD;
    do_load("load_a", img_a);
    img_b = rand_img();
    do_load("load_while_full", img_b);

    for (int i = 0; i < NWORDS; i++) begin
      bus_rd($sformatf("drain%0d", i), 3'd3);
      if (i == 0) chk("word0_const", 32'(readdata), 32'h0000_ABCD);
      if (i == 1) chk("word1_const", 32'(readdata), 32'h0000_0001);
      if (i == NWORDS - 2) chk("done_before_last", 32'(done), 32'h0);
    end
    chk("done_after_last", 32'(done), 32'h1);
    bus_rd("drained_data", 3'd3);
    chk("drained_data_const", 32'(readdata), 32'h0);
    bus_rd("drained_status", 3'd0);
    chk("drained_status_const", 32'(readdata), 32'h0000_00B9);

    bus_wr("rewind_drained", 3'd1, 16'h0001);
    bus_rd("after_rewind0", 3'd3);
    chk("rewind_word0", 32'(readdata), 32'h0000_ABCD);
    for (int i = 1; i < 10; i++) bus_rd($sformatf("part%0d", i), 3'd3);
    bus_wr("rewind_mid", 3'd1, 16'h0001);
    bus_rd("after_rewind1", 3'd3);
    chk("rewind_mid_word0", 32'(readdata), 32'h0000_ABCD);
    bus_rd("pos1", 3'd3);
    bus_rd("pos2", 3'd3);
    bus_wr("data_write_ignored", 3'd3, 16'hFFFF);
    bus_wr("status_write_ignored", 3'd0, 16'h0003);
`ifdef IMG_READBACK_PEEK_EN
    bus_rd("peek_a", 3'd4);
    chk("peek_a_word3", 32'(readdata), 32'(img_a[3*WORD_W +: WORD_W]));
    bus_rd("peek_b", 3'd4);
    chk("peek_b_word3", 32'(readdata), 32'(img_a[3*WORD_W +: WORD_W]));
`else
    bus_rd("peek_off", 3'd4);
    chk("peek_off_const", 32'(readdata), 32'h0);
`endif
    bus_rd("status_ptr3", 3'd0);
    chk("status_ptr3_const", 32'(readdata), 32'h0000_0043);
    step("rd_and_wr", 1'b0, '0, 1'b1, 1'b1, 1'b1, 3'd1, 16'h0002);
    bus_rd("still_full", 3'd0);

    bus_wr("release_both", 3'd1, 16'h0003);
    chk("release_ready", 32'(load_ready), 32'h1);
    bus_rd("released_data", 3'd3);
    step("load_with_ctrl", 1'b1, img_b, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0002);
    bus_rd("img_b0", 3'd3);
    chk("img_b_word0", 32'(readdata), 32'(img_b[WORD_W-1:0]));
    bus_rd("img_b1", 3'd3);

    for (int n = 0; n < 120; n++) begin
      int op;
      logic [2:0] a;
      op = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd3;
      if (op < 2) step($sformatf("rnd_load%0d", n), 1'b1, rand_img(), 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
      else if (op < 8) bus_rd($sformatf("rnd_rd%0d", n), a);
      else if (op == 8) bus_wr($sformatf("rnd_ctrl%0d", n), 3'd1, 16'($urandom_range(0, 3)));
      else step($sformatf("rnd_mix%0d", n), 1'b0, '0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
    end

    bus_wr("pre_reset_release", 3'd1, 16'h0002);
    do_load("pre_reset_load", rand_img());
    bus_rd("pre_reset_rd0", 3'd3);
    bus_rd("pre_reset_rd1", 3'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset.rdata", 32'(readdata), 32'h0);
    chk("midreset.done", 32'(done), 32'h0);
    chk("midreset.ready", 32'(load_ready), 32'h1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd("post_reset_status", 3'd0);
    bus_rd("post_reset_data", 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
